// File: rtl/adc_fe_pkg.sv
// adc_fe_pkg: shared pattern modes and word helpers for the ADC front-end emulator
package adc_fe_pkg;
  localparam int MAX_SAMPLE_BITS = 64;
  typedef enum logic [1:0] {PAT_DATA, PAT_TRAIN, PAT_RAMP, PAT_ZERO} pat_mode_e;
  function automatic int beats(input int sample_bits);
    return sample_bits / 2;
  endfunction
  function automatic logic [MAX_SAMPLE_BITS-1:0] train_word(input int sample_bits);
    logic [MAX_SAMPLE_BITS-1:0] w;
    for (int i = 0; i < MAX_SAMPLE_BITS; i++) w[i] = (i >= sample_bits / 2) && (i < sample_bits);
    return w;
  endfunction
endpackage

// File: rtl/lane_serializer_core.sv
// lane_serializer_core: one lane, MSB-first rise/fall pairs with a toggleable one-bit delay
module lane_serializer_core #(
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   dco_clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [SAMPLE_BITS-1:0] word,
  input  logic                   skew_pulse,
  output logic                   tx_rise,
  output logic                   tx_fall
);
  logic [SAMPLE_BITS-1:0] sh, src;
  logic skew, skew_n, ur, uf, prev_fall;
  // unskewed bit pair comes from the new word on a load, else from the shifter
  always_comb begin
    src = load ? word : sh;
    ur = src[SAMPLE_BITS-1];
    uf = src[SAMPLE_BITS-2];
    skew_n = skew ^ skew_pulse;
  end
  // skewed lane sends last cycle's fall bit first, delaying the stream by one bit
  always_ff @(posedge dco_clk) begin
    if (rst) begin
      sh <= '0;
      skew <= 1'b0;
      prev_fall <= 1'b0;
      tx_rise <= 1'b0;
      tx_fall <= 1'b0;
    end else begin
      sh <= src << 2;
      skew <= skew_n;
      prev_fall <= uf;
      tx_rise <= skew_n ? prev_fall : ur;
      tx_fall <= skew_n ? ur : uf;
    end
  end
endmodule

// File: rtl/adc_lane_serializer.sv
// adc_lane_serializer: multi-lane DDR sample serializer with frame lane, patterns and skew injection
module adc_lane_serializer
  import adc_fe_pkg::*;
#(
  parameter int LANES       = 8,
  parameter int SAMPLE_BITS = 16
) (
  input  logic                         dco_clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [LANES*SAMPLE_BITS-1:0] s_data,
  input  logic [1:0]                   pattern_mode,
  input  logic [LANES-1:0]             skew_pulse,
  output logic [LANES-1:0]             tx_rise,
  output logic [LANES-1:0]             tx_fall,
  output logic                         fco_rise,
  output logic                         fco_fall,
  output logic                         frame_start,
  output logic                         underrun
);
  localparam int BEATS = beats(SAMPLE_BITS);
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  localparam logic [MAX_SAMPLE_BITS-1:0] TRAIN_FULL = train_word(SAMPLE_BITS);
  localparam logic [SAMPLE_BITS-1:0] TRAIN = TRAIN_FULL[SAMPLE_BITS-1:0];
  pat_mode_e mode;
  logic first, hold_valid, load, accept, avail;
  logic [BW-1:0] beat;
  logic [LANES*SAMPLE_BITS-1:0] hold_data, data_src;
  logic [SAMPLE_BITS-1:0] ramp;
  // a word arriving while hold is empty bypasses straight into a same-cycle load
  always_comb begin
    mode = pat_mode_e'(pattern_mode);
    load = first || beat == LAST;
    s_ready = !rst && (!hold_valid || load);
    accept = s_valid && s_ready;
    avail = hold_valid || accept;
    data_src = hold_valid ? hold_data : accept ? s_data : '0;
  end
  // frame timing, hold buffer, ramp source and sticky underrun
  always_ff @(posedge dco_clk) begin
    if (rst) begin
      first <= 1'b1;
      beat <= '0;
      hold_valid <= 1'b0;
      hold_data <= '0;
      ramp <= '0;
      underrun <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      first <= 1'b0;
      beat <= load ? '0 : beat + 1'b1;
      hold_valid <= hold_valid ? (!load || accept) : (accept && !load);
      if (accept) hold_data <= s_data;
      ramp <= (load && mode == PAT_RAMP) ? ramp + 1'b1 : ramp;
      underrun <= underrun || (load && mode == PAT_DATA && !avail);
      frame_start <= load;
    end
  end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [SAMPLE_BITS-1:0] word;
    // per-lane source chosen by the mode sampled at load
    always_comb word = mode == PAT_DATA ? data_src[g*SAMPLE_BITS +: SAMPLE_BITS] :
                       mode == PAT_TRAIN ? TRAIN : mode == PAT_RAMP ? ramp : '0;
    lane_serializer_core #(.SAMPLE_BITS(SAMPLE_BITS)) u_core (
      .dco_clk    (dco_clk),
      .rst        (rst),
      .load       (load),
      .word       (word),
      .skew_pulse (skew_pulse[g]),
      .tx_rise    (tx_rise[g]),
      .tx_fall    (tx_fall[g])
    );
  end
  lane_serializer_core #(.SAMPLE_BITS(SAMPLE_BITS)) u_fco (
    .dco_clk    (dco_clk),
    .rst        (rst),
    .load       (load),
    .word       (TRAIN),
    .skew_pulse (1'b0),
    .tx_rise    (fco_rise),
    .tx_fall    (fco_fall)
  );
endmodule

// File: tb/tb_adc_lane_serializer.sv
// tb_adc_lane_serializer: table-driven and scoreboard checks of the lane serializer
module tb_adc_lane_serializer;
  localparam int LANES = 2;
  localparam int SB = 8;
  logic dco_clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [LANES*SB-1:0] s_data = '0;
  logic [1:0] pattern_mode = 2'd0;
  logic [LANES-1:0] skew_pulse = '0;
  logic [LANES-1:0] tx_rise, tx_fall;
  logic fco_rise, fco_fall, frame_start, underrun;
  int checks = 0;
  int errors = 0;
  logic [LANES*SB-1:0] sb_q[$];
  typedef struct {
    logic [1:0] mode;
    logic       valid;
    logic [7:0] d0, d1, e0, e1, inc;
    int         frames;
    logic       und;
  } vec_t;
  vec_t vecs[6];

  always #5 dco_clk = ~dco_clk;

  adc_lane_serializer #(.LANES(LANES), .SAMPLE_BITS(SB)) dut (
    .dco_clk      (dco_clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .pattern_mode (pattern_mode),
    .skew_pulse   (skew_pulse),
    .tx_rise      (tx_rise),
    .tx_fall      (tx_fall),
    .fco_rise     (fco_rise),
    .fco_fall     (fco_fall),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always @(posedge dco_clk)
    if (!rst && s_valid && s_ready && pattern_mode == 2'd0) sb_q.push_back(s_data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " tx_rise"}, 32'(tx_rise), 0);
    chk({tag, " tx_fall"}, 32'(tx_fall), 0);
    chk({tag, " fco"}, 32'({fco_rise, fco_fall}), 0);
    chk({tag, " frame_start"}, 32'(frame_start), 0);
    chk({tag, " underrun"}, 32'(underrun), 0);
    chk({tag, " s_ready"}, 32'(s_ready), 0);
  endtask

  task automatic apply_reset();
    @(negedge dco_clk);
    rst = 1'b1;
    s_valid = 1'b0;
    skew_pulse = '0;
    @(negedge dco_clk);
    chk_idle("reset");
    sb_q.delete();
  endtask

  task automatic check_frame(input string tag);
    logic [SB-1:0] w0, w1, wf;
    logic [LANES*SB-1:0] exp;
    int n = 0;
    do begin
      @(negedge dco_clk);
      n++;
    end while (!frame_start && n < 8);
    chk({tag, " frame gap"}, 32'(n), 1);
    if (!frame_start) return;
    for (int b = 0; b < SB / 2; b++) begin
      if (b > 0) begin
        @(negedge dco_clk);
        chk({tag, " frame_start low"}, 32'(frame_start), 0);
      end
      w0[SB-1-2*b] = tx_rise[0];
      w0[SB-2-2*b] = tx_fall[0];
      w1[SB-1-2*b] = tx_rise[1];
      w1[SB-2-2*b] = tx_fall[1];
      wf[SB-1-2*b] = fco_rise;
      wf[SB-2-2*b] = fco_fall;
    end
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got frame %0h_%0h, expected none queued", tag, w1, w0);
      return;
    end
    exp = sb_q.pop_front();
    chk({tag, " lane0"}, 32'(w0), 32'(exp[SB-1:0]));
    chk({tag, " lane1"}, 32'(w1), 32'(exp[2*SB-1:SB]));
    chk({tag, " fco"}, 32'(wf), 32'hF0);
  endtask

  initial begin
    logic [7:0] w, t0, t1;
    logic sk;
    int b, pb;
    vecs[0] = '{2'd0, 1'b1, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 4, 1'b0};
    vecs[1] = '{2'd0, 1'b1, 8'h96, 8'h01, 8'h00, 8'h00, 8'h00, 3, 1'b0};
    vecs[2] = '{2'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3, 1'b1};
    vecs[3] = '{2'd1, 1'b0, 8'h00, 8'h00, 8'hF0, 8'hF0, 8'h00, 3, 1'b0};
    vecs[4] = '{2'd2, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 5, 1'b0};
    vecs[5] = '{2'd3, 1'b1, 8'hFF, 8'h77, 8'h00, 8'h00, 8'h00, 3, 1'b0};
    foreach (vecs[i]) begin
      apply_reset();
      pattern_mode = vecs[i].mode;
      s_valid = vecs[i].valid;
      s_data = {vecs[i].d1, vecs[i].d0};
      if (!(vecs[i].mode == 2'd0 && vecs[i].valid))
        for (int k = 0; k < vecs[i].frames; k++) begin
          t0 = vecs[i].e0 + 8'(k) * vecs[i].inc;
          t1 = vecs[i].e1 + 8'(k) * vecs[i].inc;
          sb_q.push_back({t1, t0});
        end
      rst = 1'b0;
      #1 chk($sformatf("vec%0d first-cycle s_ready", i), 32'(s_ready), 1);
      for (int k = 0; k < vecs[i].frames; k++) check_frame($sformatf("vec%0d f%0d", i, k));
      chk($sformatf("vec%0d underrun", i), 32'(underrun), 32'(vecs[i].und));
    end

    apply_reset();
    pattern_mode = 2'd2;
    for (int k = 0; k < 258; k++) begin
      t0 = 8'(k);
      sb_q.push_back({t0, t0});
    end
    rst = 1'b0;
    for (int k = 0; k < 258; k++) check_frame($sformatf("ramp f%0d", k));

    apply_reset();
    pattern_mode = 2'd0;
    s_data = {8'hF0, 8'hF0};
    s_valid = 1'b1;
    rst = 1'b0;
    check_frame("skew pre");
    w = 8'hF0;
    sk = 1'b0;
    for (int j = 0; j < 13; j++) begin
      skew_pulse = (j == 1 || j == 7) ? 2'b01 : 2'b00;
      @(negedge dco_clk);
      if (skew_pulse[0]) sk = ~sk;
      b = j % 4;
      pb = (j + 3) % 4;
      chk($sformatf("skew c%0d lane0 rise", j), 32'(tx_rise[0]), 32'(sk ? w[SB-2-2*pb] : w[SB-1-2*b]));
      chk($sformatf("skew c%0d lane0 fall", j), 32'(tx_fall[0]), 32'(sk ? w[SB-1-2*b] : w[SB-2-2*b]));
      chk($sformatf("skew c%0d lane1", j), 32'({tx_rise[1], tx_fall[1]}), 32'({w[SB-1-2*b], w[SB-2-2*b]}));
      chk($sformatf("skew c%0d fco", j), 32'({fco_rise, fco_fall}), 32'({w[SB-1-2*b], w[SB-2-2*b]}));
      chk($sformatf("skew c%0d frame_start", j), 32'(frame_start), 32'(b == 0));
    end
    skew_pulse = '0;

    apply_reset();
    pattern_mode = 2'd0;
    s_data = {8'h3C, 8'hA5};
    s_valid = 1'b1;
    rst = 1'b0;
    check_frame("mid pre");
    repeat (3) @(negedge dco_clk);
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge dco_clk);
    chk_idle("mid reset");
    sb_q.delete();
    sb_q.push_back('0);
    rst = 1'b0;
    check_frame("mid post");
    chk("mid underrun", 32'(underrun), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_lane_serializer.md
Name: adc_lane_serializer

Overview:
- Transmit-side counterpart of the DDR lane capture/bitslip path: serializes parallel per-lane ADC sample words into rise/fall bit pairs per dco_clk cycle, MSB first, plus a frame (FCO) lane.
- Used as the ADC emulator in loopback benches and as the pattern source for receiver bitslip training.
- Provides per-lane one-bit skew injection so receiver realignment can be exercised.

Parameters:
- LANES, 8, number of data lanes.
- SAMPLE_BITS, 16, bits per sample word per lane. Must be even and at least 4. BEATS = SAMPLE_BITS/2 dco cycles per frame.

Ports:
- dco_clk  in  1  bit clock. Each cycle carries one rise bit and one fall bit per lane.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  sample word valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- s_data  in  LANES*SAMPLE_BITS  lane i occupies [i*SAMPLE_BITS +: SAMPLE_BITS].
- pattern_mode  in  2  0=data, 1=training, 2=ramp, 3=all-zero. Sampled at frame load.
- skew_pulse  in  LANES  per-lane pulse that toggles that lane's one-bit delay.
- tx_rise  out  LANES  bit driven in the first half of the cycle (registered).
- tx_fall  out  LANES  bit driven in the second half of the cycle (registered).
- fco_rise  out  1  frame lane, first-half bit (registered).
- fco_fall  out  1  frame lane, second-half bit (registered).
- frame_start  out  1  high in the cycle tx_* carries beat 0 of a frame.
- underrun  out  1  sticky flag: a frame loaded with no word available.

Behaviour:
- Reset (synchronous, rst=1):
  - All outputs 0, s_ready 0.
  - beat counter 0, hold buffer empty, shift registers 0, skew state 0, ramp counter 0, underrun 0.
  - First cycle after reset: s_ready=1; the first frame load occurs in that same cycle.
- Hold buffer: one entry. s_ready = !hold_valid || load_this_cycle, so back-to-back words stream with no bubble.
- Frame load:
  - Occurs when beat==BEATS-1, or in the first cycle after reset.
  - Shift registers take the source selected by pattern_mode:
    - mode 0: hold contents.
    - mode 1: training word, per lane 1s in the upper SAMPLE_BITS/2 bits, 0s in the lower half.
    - mode 2: ramp counter value (SAMPLE_BITS wide, wraps modulo 2^SAMPLE_BITS), same on all lanes; increments at each load.
    - mode 3: zeros.
  - In mode 0 with hold empty: load zeros and set underrun. underrun clears only on rst.
  - A load consumes hold whenever hold is valid, in every mode, so upstream never stalls.
  - Simultaneous accept and load in the same cycle: the load takes the old hold; the new word fills hold.
- Beat k (0..BEATS-1): unskewed rise bit = word[SAMPLE_BITS-1-2k], fall bit = word[SAMPLE_BITS-2-2k].
- Latency: a word accepted in cycle c with hold previously empty, and the next load at cycle L ≥ c, appears on tx_* at beat 0 in cycle L+1.
- frame_start is registered and aligned to beat 0 on the outputs.
- FCO: rise/fall = 1 for bit indices ≥ SAMPLE_BITS/2, else 0. FCO is never skewed.
- Skew:
  - skew[i] toggles on skew_pulse[i], taking effect on the next output cycle.
  - Skewed lane: tx_rise[i] = previous cycle's unskewed fall bit; tx_fall[i] = current unskewed rise bit. The stream is delayed by one bit; one bit is dropped/duplicated at the toggle.
  - Previous-fall register resets to 0.
- skew_pulse on multiple lanes in one cycle: each lane toggles independently.
- pattern_mode changes mid-frame do not affect the current frame.

Decomposition:
- Shared package adc_fe_pkg:
  - pattern_mode enum: PAT_DATA, PAT_TRAIN, PAT_RAMP, PAT_ZERO.
  - function for the training word.
  - BEATS computation function.
- One sub-module, lane_serializer_core: single-lane shift register plus skew mux, instantiated LANES times. The top holds the beat counter, hold buffer, pattern selection and FCO.

Test Plan:
- LANES=2, SAMPLE_BITS=8, mode 0, continuous valid with lane0=8'hA5, lane1=8'h3C -> lane0 rise/fall per beat (1,0),(1,0),(0,1),(0,1); lane1 (0,0),(1,1),(1,1),(0,0); frame_start every 4 cycles; underrun stays 0.
- Mode 0, s_valid held low after reset -> zeros on tx_*; underrun=1 from the first frame, held until rst.
- Mode 1 -> every lane matches FCO: (1,1),(1,1),(0,0),(0,0).
- Mode 2, SAMPLE_BITS=8 -> successive frames carry 8'h00, 8'h01, 8'h02 ...; after 8'hFF the next frame is 8'h00.
- Mode 0, word 8'hF0 streamed, skew_pulse[0] once -> lane0 shifted one bit later: rise=prev fall, fall=rise; a second pulse restores alignment; lane1 and FCO unchanged.
- rst asserted mid-frame at beat 2 -> next cycle all outputs 0, s_ready=0; hold contents discarded; the following frame starts at beat 0.
